// File: rtl/word_serializer_pkg.sv
// Shared definitions for the word serializer: FSM encoding, default idle level, counter sizing.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
// Contents:
//   ser_state_e      - two-state shifter FSM encoding (idle / shifting)
//   IDLE_BIT_DEFAULT - seq_out level while nothing is being shifted
//   WIDTH_DEFAULT    - default word width
//   clog2_min1()     - bits needed to index 0..value-1, never less than 1
package word_serializer_pkg;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_SHIFT = 1'b1
   } ser_state_e;

   localparam logic        IDLE_BIT_DEFAULT = 1'b0;
   localparam int unsigned WIDTH_DEFAULT    = 8;

   // Width of a counter that must hold values 0..value-1. A floor of one
   // bit keeps the declared vectors legal for the smallest word sizes.
   function automatic int unsigned clog2_min1(input int unsigned value);
      int unsigned result;
      result = 0;
      for (int i = 0; i < 32; i++) begin
         if ((33'd1 << i) < 33'(value)) begin
            result = i + 1;
         end
      end
      if (result == 0) begin
         result = 1;
      end
      return result;
   endfunction

endpackage

// File: rtl/word_serializer_if.sv
// Bundle carrying the parallel-word handshake and the serial output of the word serializer.
// Latency: n/a (wires only).
// Backpressure: in_ready from the serializer gates in_valid; shift_en paces the serial side.
// Signals:
//   in_word/in_valid/in_ready  - parallel word handshake (transfer when in_valid && in_ready)
//   shift_en                   - bit-rate enable driven by the consumer
//   seq_out/seq_valid          - serial bit and its data/idle qualifier
//   word_done/busy             - last-bit pulse and occupancy status
interface word_serializer_if #(
   parameter int unsigned WIDTH = 8
);

   logic [WIDTH-1:0] in_word;
   logic             in_valid;
   logic             in_ready;
   logic             shift_en;
   logic             seq_out;
   logic             seq_valid;
   logic             word_done;
   logic             busy;

   // Side that produces words and consumes the serial stream.
   modport master (
      output in_word,
      output in_valid,
      output shift_en,
      input  in_ready,
      input  seq_out,
      input  seq_valid,
      input  word_done,
      input  busy
   );

   // The serializer itself.
   modport slave (
      input  in_word,
      input  in_valid,
      input  shift_en,
      output in_ready,
      output seq_out,
      output seq_valid,
      output word_done,
      output busy
   );

endinterface

// File: rtl/word_hold_buffer.sv
// One-entry valid/ready holding register in front of the shifter.
// Latency: word visible on hold_word one clock after the handshake edge.
// Backpressure: in_ready = !hold_full (registered); drained only by a pop from the FSM.
// Ports:
//   clock, reset          - clock and async active-high reset
//   in_word/in_valid      - upstream word and qualifier
//   in_ready              - buffer empty, upstream may transfer
//   pop                   - FSM takes the held word this edge
//   hold_word/hold_full   - held word and occupancy flag
module word_hold_buffer
   import word_serializer_pkg::*;
#(
   parameter int unsigned WIDTH = WIDTH_DEFAULT
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [WIDTH-1:0] in_word,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             pop,
   output logic [WIDTH-1:0] hold_word,
   output logic             hold_full
);

   logic             full_q, full_d;
   logic [WIDTH-1:0] data_q, data_d;
   logic             push;

   // Push needs an empty buffer and pop needs a full one, so the two can
   // never coincide on the same edge.
   assign push = in_valid && !full_q;

   always_comb begin
      full_d = full_q;
      data_d = data_q;
      if (push) begin
         full_d = 1'b1;
         data_d = in_word;
      end else if (pop) begin
         full_d = 1'b0;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         full_q <= 1'b0;
         data_q <= '0;
      end else begin
         full_q <= full_d;
         data_q <= data_d;
      end
   end

   assign in_ready  = !full_q;
   assign hold_word = data_q;
   assign hold_full = full_q;

endmodule

// File: rtl/word_serializer.sv
// Serializes parallel words onto seq_out, one bit per enabled clock, gap-free for back-to-back words.
// Latency: first bit on seq_out one enabled edge after the word reaches the hold buffer.
// Backpressure: single-entry hold buffer; in_ready drops while it is full, independent of shift_en.
// Ports:
//   clock, reset   - clock and async active-high reset
//   bus (slave)    - in_word/in_valid/in_ready handshake, shift_en pacing,
//                    seq_out/seq_valid serial output, word_done pulse, busy status
module word_serializer
   import word_serializer_pkg::*;
#(
   parameter int unsigned WIDTH     = WIDTH_DEFAULT,
   parameter bit          MSB_FIRST = 1'b1,
   parameter logic        IDLE_BIT  = IDLE_BIT_DEFAULT
) (
   input  logic               clock,
   input  logic               reset,
   word_serializer_if.slave   bus
);

   localparam int unsigned      CNT_W      = clog2_min1(WIDTH);
   localparam logic [CNT_W-1:0] LAST_IDX   = CNT_W'(WIDTH - 1);
   localparam logic [CNT_W-1:0] PENULT_IDX = CNT_W'(WIDTH - 2);

   logic             hold_full;
   logic             hold_pop;
   logic [WIDTH-1:0] hold_word;

   ser_state_e       state_q, state_d;
   logic [WIDTH-1:0] shreg_q, shreg_d;
   logic [CNT_W-1:0] bitcnt_q, bitcnt_d;
   logic             seq_out_q, seq_out_d;
   logic             seq_valid_q, seq_valid_d;
   logic             word_done_q, word_done_d;

   word_hold_buffer #(
      .WIDTH (WIDTH)
   ) u_hold (
      .clock     (clock),
      .reset     (reset),
      .in_word   (bus.in_word),
      .in_valid  (bus.in_valid),
      .in_ready  (bus.in_ready),
      .pop       (hold_pop),
      .hold_word (hold_word),
      .hold_full (hold_full)
   );

   // The shift register always holds the bits not yet driven, pre-aligned
   // so the next bit to go out sits at the same end as a fresh word's first bit.
   function automatic logic first_bit(input logic [WIDTH-1:0] w);
      return MSB_FIRST ? w[WIDTH-1] : w[0];
   endfunction

   function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] w);
      return MSB_FIRST ? (w << 1) : (w >> 1);
   endfunction

   always_comb begin
      state_d     = state_q;
      shreg_d     = shreg_q;
      bitcnt_d    = bitcnt_q;
      seq_out_d   = seq_out_q;
      seq_valid_d = seq_valid_q;
      word_done_d = 1'b0;
      hold_pop    = 1'b0;

      if (bus.shift_en) begin
         if ((state_q == ST_SHIFT) && (bitcnt_q != LAST_IDX)) begin
            // Mid-word: drive the next bit. Reaching the final index
            // raises word_done for the following clock only.
            seq_out_d   = first_bit(shreg_q);
            shreg_d     = advance(shreg_q);
            bitcnt_d    = bitcnt_q + 1'b1;
            word_done_d = (bitcnt_q == PENULT_IDX);
         end else if (hold_full) begin
            // Idle, or the last bit just finished: start the held word
            // immediately so consecutive words have no gap between them.
            hold_pop    = 1'b1;
            seq_out_d   = first_bit(hold_word);
            shreg_d     = advance(hold_word);
            bitcnt_d    = '0;
            seq_valid_d = 1'b1;
            state_d     = ST_SHIFT;
         end else begin
            seq_out_d   = IDLE_BIT;
            seq_valid_d = 1'b0;
            bitcnt_d    = '0;
            state_d     = ST_IDLE;
         end
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         shreg_q     <= '0;
         bitcnt_q    <= '0;
         seq_out_q   <= IDLE_BIT;
         seq_valid_q <= 1'b0;
         word_done_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         shreg_q     <= shreg_d;
         bitcnt_q    <= bitcnt_d;
         seq_out_q   <= seq_out_d;
         seq_valid_q <= seq_valid_d;
         word_done_q <= word_done_d;
      end
   end

   assign bus.seq_out   = seq_out_q;
   assign bus.seq_valid = seq_valid_q;
   assign bus.word_done = word_done_q;
   assign bus.busy      = (state_q == ST_SHIFT) || hold_full;

endmodule

// File: tb/tb_word_serializer.sv
// Directed bench for word_serializer: MSB-first and LSB-first instances, hand-computed bit streams.
// Latency: inputs driven and outputs sampled 1 time unit after each rising edge.
// Backpressure: bench honours in_ready; one scenario holds in_valid against a full buffer.
module tb_word_serializer;

   logic clock = 1'b0;
   logic reset = 1'b1;
   int   checks = 0;
   int   failures = 0;

   always #5 clock = ~clock;

   word_serializer_if #(.WIDTH(8)) bus_m ();
   word_serializer_if #(.WIDTH(8)) bus_l ();

   word_serializer #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) dut_m (
      .clock (clock),
      .reset (reset),
      .bus   (bus_m)
   );

   word_serializer #(.WIDTH(8), .MSB_FIRST(1'b0), .IDLE_BIT(1'b0)) dut_l (
      .clock (clock),
      .reset (reset),
      .bus   (bus_l)
   );

   // Downstream Moore "1111" run detector fed by the MSB-first stream.
   logic [2:0] ones_q;
   logic       det;
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         ones_q <= 3'd0;
      end else if (bus_m.shift_en) begin
         ones_q <= (bus_m.seq_valid && bus_m.seq_out) ?
                   ((ones_q == 3'd4) ? 3'd4 : ones_q + 3'd1) : 3'd0;
      end
   end
   assign det = (ones_q == 3'd4);

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic test_reset();
      step();
      step();
      checks++; if (bus_m.seq_out !== 1'b0)   begin failures++; $display("FAIL rst_seq_out got=%b exp=0", bus_m.seq_out); end
      checks++; if (bus_m.seq_valid !== 1'b0) begin failures++; $display("FAIL rst_seq_valid got=%b exp=0", bus_m.seq_valid); end
      checks++; if (bus_m.in_ready !== 1'b1)  begin failures++; $display("FAIL rst_in_ready got=%b exp=1", bus_m.in_ready); end
      checks++; if (bus_m.busy !== 1'b0)      begin failures++; $display("FAIL rst_busy got=%b exp=0", bus_m.busy); end
      checks++; if (bus_m.word_done !== 1'b0) begin failures++; $display("FAIL rst_word_done got=%b exp=0", bus_m.word_done); end
      reset = 1'b0;
      step();
      checks++; if (bus_m.seq_valid !== 1'b0 || bus_m.in_ready !== 1'b1) begin
         failures++; $display("FAIL post_rst_idle got valid=%b ready=%b exp valid=0 ready=1", bus_m.seq_valid, bus_m.in_ready);
      end
   endtask

   task automatic test_single_word();
      logic [7:0] w;
      int det_cnt;
      w = 8'hF0;
      det_cnt = 0;
      bus_m.in_word = w;
      bus_m.in_valid = 1'b1;
      step();  // handshake edge
      bus_m.in_valid = 1'b0;
      checks++; if (bus_m.seq_valid !== 1'b0 || bus_m.busy !== 1'b1) begin
         failures++; $display("FAIL t1_accept got valid=%b busy=%b exp valid=0 busy=1", bus_m.seq_valid, bus_m.busy);
      end
      for (int i = 0; i < 8; i++) begin
         step();
         if (det) det_cnt++;
         checks++; if (bus_m.seq_out !== w[7-i] || bus_m.seq_valid !== 1'b1) begin
            failures++; $display("FAIL t1_bit%0d got out=%b valid=%b exp out=%b valid=1", i, bus_m.seq_out, bus_m.seq_valid, w[7-i]);
         end
         checks++; if (bus_m.word_done !== (i == 7)) begin
            failures++; $display("FAIL t1_done%0d got=%b exp=%b", i, bus_m.word_done, (i == 7));
         end
      end
      for (int i = 0; i < 3; i++) begin
         step();
         if (det) det_cnt++;
         checks++; if (bus_m.seq_out !== 1'b0 || bus_m.seq_valid !== 1'b0 || bus_m.word_done !== 1'b0) begin
            failures++; $display("FAIL t1_idle%0d got out=%b valid=%b done=%b exp 0 0 0", i, bus_m.seq_out, bus_m.seq_valid, bus_m.word_done);
         end
      end
      checks++; if (bus_m.busy !== 1'b0) begin failures++; $display("FAIL t1_busy_end got=%b exp=0", bus_m.busy); end
      checks++; if (det_cnt != 1) begin failures++; $display("FAIL t1_moore1111 got=%0d cycles exp=1", det_cnt); end
   endtask

   task automatic test_back_to_back();
      logic [15:0] stream;
      stream = 16'h0FFF;
      bus_m.in_word = 8'h0F;
      bus_m.in_valid = 1'b1;
      step();  // accept 0F
      checks++; if (bus_m.in_ready !== 1'b0 || bus_m.seq_valid !== 1'b0) begin
         failures++; $display("FAIL t2_first_accept got ready=%b valid=%b exp 0 0", bus_m.in_ready, bus_m.seq_valid);
      end
      bus_m.in_word = 8'hFF;
      for (int i = 0; i < 16; i++) begin
         step();
         checks++; if (bus_m.seq_valid !== 1'b1 || bus_m.seq_out !== stream[15-i]) begin
            failures++; $display("FAIL t2_bit%0d got out=%b valid=%b exp out=%b valid=1", i, bus_m.seq_out, bus_m.seq_valid, stream[15-i]);
         end
         checks++; if (bus_m.word_done !== (i == 7 || i == 15)) begin
            failures++; $display("FAIL t2_done%0d got=%b exp=%b", i, bus_m.word_done, (i == 7 || i == 15));
         end
         checks++; if (bus_m.in_ready !== (i == 0 || i >= 8)) begin
            failures++; $display("FAIL t2_ready%0d got=%b exp=%b", i, bus_m.in_ready, (i == 0 || i >= 8));
         end
         if (i == 1) bus_m.in_valid = 1'b0;
      end
      step();
      checks++; if (bus_m.seq_valid !== 1'b0 || bus_m.seq_out !== 1'b0) begin
         failures++; $display("FAIL t2_tail got out=%b valid=%b exp 0 0", bus_m.seq_out, bus_m.seq_valid);
      end
   endtask

   task automatic test_shift_enable();
      logic [7:0] w;
      w = 8'hA5;
      bus_m.shift_en = 1'b0;
      bus_m.in_word = w;
      bus_m.in_valid = 1'b1;
      step();  // accepted even with shift_en low
      bus_m.in_valid = 1'b0;
      step();
      checks++; if (bus_m.seq_valid !== 1'b0 || bus_m.busy !== 1'b1) begin
         failures++; $display("FAIL t3_stalled got valid=%b busy=%b exp 0 1", bus_m.seq_valid, bus_m.busy);
      end
      for (int i = 0; i < 8; i++) begin
         bus_m.shift_en = 1'b1;
         for (int s = 0; s < 3; s++) begin
            step();
            bus_m.shift_en = 1'b0;
            checks++; if (bus_m.seq_out !== w[7-i] || bus_m.seq_valid !== 1'b1) begin
               failures++; $display("FAIL t3_bit%0d_s%0d got out=%b valid=%b exp out=%b valid=1", i, s, bus_m.seq_out, bus_m.seq_valid, w[7-i]);
            end
            checks++; if (bus_m.word_done !== (i == 7 && s == 0)) begin
               failures++; $display("FAIL t3_done%0d_s%0d got=%b exp=%b", i, s, bus_m.word_done, (i == 7 && s == 0));
            end
         end
      end
      bus_m.shift_en = 1'b1;
      step();
      checks++; if (bus_m.seq_valid !== 1'b0 || bus_m.seq_out !== 1'b0) begin
         failures++; $display("FAIL t3_tail got out=%b valid=%b exp 0 0", bus_m.seq_out, bus_m.seq_valid);
      end
   endtask

   task automatic test_lsb_first();
      logic [7:0] w;
      w = 8'h01;
      bus_l.in_word = w;
      bus_l.in_valid = 1'b1;
      step();
      bus_l.in_valid = 1'b0;
      for (int i = 0; i < 8; i++) begin
         step();
         checks++; if (bus_l.seq_out !== w[i] || bus_l.seq_valid !== 1'b1) begin
            failures++; $display("FAIL t4_bit%0d got out=%b valid=%b exp out=%b valid=1", i, bus_l.seq_out, bus_l.seq_valid, w[i]);
         end
      end
      checks++; if (bus_l.word_done !== 1'b1) begin failures++; $display("FAIL t4_done got=%b exp=1", bus_l.word_done); end
      step();
      checks++; if (bus_l.seq_valid !== 1'b0) begin failures++; $display("FAIL t4_tail got=%b exp=0", bus_l.seq_valid); end
   endtask

   task automatic test_reset_mid_word();
      int stray;
      stray = 0;
      bus_m.in_word = 8'hFF;
      bus_m.in_valid = 1'b1;
      step();  // accept FF
      bus_m.in_word = 8'h3C;
      step();  // bit 0 out, buffer empties
      step();  // bit 1 out, 3C accepted
      bus_m.in_valid = 1'b0;
      step();  // bit 2 out
      checks++; if (bus_m.seq_valid !== 1'b1 || bus_m.seq_out !== 1'b1 || bus_m.in_ready !== 1'b0) begin
         failures++; $display("FAIL t5_pre got out=%b valid=%b ready=%b exp 1 1 0", bus_m.seq_out, bus_m.seq_valid, bus_m.in_ready);
      end
      #2;
      reset = 1'b1;
      #1;
      checks++; if (bus_m.seq_out !== 1'b0 || bus_m.seq_valid !== 1'b0) begin
         failures++; $display("FAIL t5_async_out got out=%b valid=%b exp 0 0", bus_m.seq_out, bus_m.seq_valid);
      end
      checks++; if (bus_m.in_ready !== 1'b1 || bus_m.busy !== 1'b0) begin
         failures++; $display("FAIL t5_async_ready got ready=%b busy=%b exp 1 0", bus_m.in_ready, bus_m.busy);
      end
      step();
      reset = 1'b0;
      for (int i = 0; i < 12; i++) begin
         step();
         if (bus_m.seq_valid) stray++;
      end
      checks++; if (stray != 0) begin failures++; $display("FAIL t5_no_bits got=%0d exp=0", stray); end
   endtask

   task automatic test_scoreboard();
      logic [7:0] words [3];
      logic [7:0] got [$];
      int         acc_cyc [3];
      int         exp_cyc [3];
      int         n_acc, nbits, first_v, last_v;
      logic       hs, rdy_prev;
      logic [7:0] cur;
      words[0] = 8'hC3; words[1] = 8'h5A; words[2] = 8'h96;
      exp_cyc[0] = 0;   exp_cyc[1] = 2;   exp_cyc[2] = 10;
      n_acc = 0; nbits = 0; first_v = -1; last_v = -1; cur = 8'h00;
      acc_cyc[0] = -1; acc_cyc[1] = -1; acc_cyc[2] = -1;
      bus_m.shift_en = 1'b1;
      bus_m.in_word = words[0];
      bus_m.in_valid = 1'b1;
      rdy_prev = bus_m.in_ready;
      for (int cyc = 0; cyc < 40; cyc++) begin
         hs = bus_m.in_valid && rdy_prev;
         step();
         if (hs && n_acc < 3) begin
            acc_cyc[n_acc] = cyc;
            n_acc++;
            if (n_acc < 3) bus_m.in_word = words[n_acc];
            else bus_m.in_valid = 1'b0;
         end
         if (bus_m.seq_valid) begin
            cur = {cur[6:0], bus_m.seq_out};
            nbits++;
            if (first_v < 0) first_v = cyc;
            last_v = cyc;
            if (nbits % 8 == 0) got.push_back(cur);
         end
         rdy_prev = bus_m.in_ready;
      end
      bus_m.in_valid = 1'b0;
      checks++; if (n_acc != 3) begin failures++; $display("FAIL t6_accepts got=%0d exp=3", n_acc); end
      for (int k = 0; k < 3; k++) begin
         checks++; if (acc_cyc[k] != exp_cyc[k]) begin
            failures++; $display("FAIL t6_accept_cycle%0d got=%0d exp=%0d", k, acc_cyc[k], exp_cyc[k]);
         end
      end
      checks++; if (nbits != 24 || (last_v - first_v + 1) != 24) begin
         failures++; $display("FAIL t6_contiguous got bits=%0d span=%0d exp 24 24", nbits, last_v - first_v + 1);
      end
      checks++; if (got.size() != 3) begin
         failures++; $display("FAIL t6_word_count got=%0d exp=3", got.size());
      end else begin
         for (int k = 0; k < 3; k++) begin
            checks++; if (got[k] !== words[k]) begin
               failures++; $display("FAIL t6_word%0d got=%h exp=%h", k, got[k], words[k]);
            end
         end
      end
   endtask

   initial begin
      bus_m.in_word = 8'h00; bus_m.in_valid = 1'b0; bus_m.shift_en = 1'b1;
      bus_l.in_word = 8'h00; bus_l.in_valid = 1'b0; bus_l.shift_en = 1'b1;
      test_reset();
      test_single_word();
      test_back_to_back();
      test_shift_enable();
      test_lsb_first();
      test_reset_mid_word();
      test_scoreboard();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
